// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter.
// Sends one frame per tx_valid/tx_ready handshake: a start bit, DATA_BITS
// data bits LSB first, an optional parity bit, then STOP_BITS stop bits.
// Every bit is held for FREQ/BAUD clock cycles.
module uart_tx_cfg #(
    parameter int FREQ      = 12500000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int DIV    = FREQ / BAUD;
    localparam int BAUD_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_cfg: FREQ/BAUD must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS must be in 5..8");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [BAUD_W-1:0]     baud_cnt, baud_cnt_n;
    logic [2:0]            bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]  shift_reg, shift_reg_n;
    logic                  parity_bit, parity_bit_n;
    logic                  tx_q, tx_n;
    logic                  done_q, done_n;
    logic                  baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);

    // State register and all datapath flops; tx comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift_reg  <= shift_reg_n;
            parity_bit <= parity_bit_n;
            tx_q       <= tx_n;
            done_q     <= done_n;
        end
    end

    // Next-state logic; tx_n is the line level for the cycle after this edge
    always_comb begin
        state_n      = state;
        baud_cnt_n   = baud_end ? '0 : baud_cnt + 1'b1;
        bit_cnt_n    = bit_cnt;
        shift_reg_n  = shift_reg;
        parity_bit_n = parity_bit;
        tx_n         = tx_q;
        done_n       = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_n = '0;
                bit_cnt_n  = '0;
                tx_n       = 1'b1;
                if (tx_valid) begin
                    shift_reg_n  = tx_data;
                    parity_bit_n = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    state_n      = START;
                    tx_n         = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_n = DATA;
                    tx_n    = shift_reg[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_n = '0;
                        if (PARITY != 0) begin
                            state_n = PAR;
                            tx_n    = parity_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_cnt_n   = bit_cnt + 3'd1;
                        shift_reg_n = {1'b0, shift_reg[DATA_BITS-1:1]};
                        tx_n        = shift_reg[1];
                    end
                end
            end
            PAR: begin
                if (baud_end) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                    tx_n      = 1'b1;
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_n   = IDLE;
                        bit_cnt_n = '0;
                        done_n    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    assign tx_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign tx         = tx_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg with DIV = 4.
// Four instances cover 8N1, 8E1, 8O1 and 7N2 frames.
module tb_uart_tx_cfg;

    localparam int TB_FREQ = 12500000;
    localparam int TB_BAUD = 3125000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 8N1
    logic [7:0] d1 = 8'h00;
    logic       v1 = 1'b0;
    logic       r1, tx1, b1, f1;
    // 8E1 and 8O1 share stimulus
    logic [7:0] dp = 8'h00;
    logic       vp = 1'b0;
    logic       re, txe, be, fe;
    logic       ro, txo, bo, fo;
    // 7N2
    logic [6:0] d7 = 7'h00;
    logic       v7 = 1'b0;
    logic       r7, tx7, b7, f7;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt1 = 0;

    // 100 MHz nominal bench clock
    always #5 clk = ~clk;

    // Counts frame_done pulses on the 8N1 instance
    always @(posedge clk) begin
        if (f1 === 1'b1) done_cnt1 <= done_cnt1 + 1;
    end

    uart_tx_cfg #(.FREQ(TB_FREQ), .BAUD(TB_BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1),
        .tx_ready(r1), .tx(tx1), .busy(b1), .frame_done(f1));

    uart_tx_cfg #(.FREQ(TB_FREQ), .BAUD(TB_BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .tx_data(dp), .tx_valid(vp),
        .tx_ready(re), .tx(txe), .busy(be), .frame_done(fe));

    uart_tx_cfg #(.FREQ(TB_FREQ), .BAUD(TB_BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .tx_data(dp), .tx_valid(vp),
        .tx_ready(ro), .tx(txo), .busy(bo), .frame_done(fo));

    uart_tx_cfg #(.FREQ(TB_FREQ), .BAUD(TB_BAUD), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst_n(rst_n), .tx_data(d7), .tx_valid(v7),
        .tx_ready(r7), .tx(tx7), .busy(b7), .frame_done(f7));

    task automatic test_reset();
        #23;
        n_cmp++;
        if ({tx1, r1, b1, f1} !== 4'b1100) begin
            n_err++;
            $display("[TB] FAIL reset_8n1: got tx/ready/busy/done=%b expected 1100", {tx1, r1, b1, f1});
        end
        n_cmp++;
        if ({txe, re, be, fe} !== 4'b1100) begin
            n_err++;
            $display("[TB] FAIL reset_8e1: got tx/ready/busy/done=%b expected 1100", {txe, re, be, fe});
        end
        n_cmp++;
        if ({txo, ro, bo, fo} !== 4'b1100) begin
            n_err++;
            $display("[TB] FAIL reset_8o1: got tx/ready/busy/done=%b expected 1100", {txo, ro, bo, fo});
        end
        n_cmp++;
        if ({tx7, r7, b7, f7} !== 4'b1100) begin
            n_err++;
            $display("[TB] FAIL reset_7n2: got tx/ready/busy/done=%b expected 1100", {tx7, r7, b7, f7});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_8n1();
        logic [15:0] exp_bits;
        int seen;
        exp_bits = {6'b0, 1'b1, 8'hA5, 1'b0};
        seen = 0;
        d1 = 8'hA5;
        v1 = 1'b1;
        n_cmp++;
        if (r1 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL 8n1_ready_idle: got %b expected 1", r1);
        end
        @(posedge clk);
        #1;
        v1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            n_cmp++;
            if (tx1 !== exp_bits[k/4]) begin
                n_err++;
                $display("[TB] FAIL 8n1_tx cycle %0d: got %b expected %b", k, tx1, exp_bits[k/4]);
            end
            n_cmp++;
            if (b1 !== 1'b1 || r1 !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL 8n1_busy cycle %0d: got busy/ready=%b%b expected 10", k, b1, r1);
            end
            if (f1 === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({f1, r1, b1, tx1} !== 4'b1101) begin
            n_err++;
            $display("[TB] FAIL 8n1_done: got done/ready/busy/tx=%b expected 1101", {f1, r1, b1, tx1});
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("[TB] FAIL 8n1_early_done: got %0d pulses expected 0", seen);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (f1 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL 8n1_done_width: got %b expected 0", f1);
        end
    endtask

    task automatic test_parity();
        logic [15:0] exp_e;
        logic [15:0] exp_o;
        exp_e = {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
        exp_o = {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
        dp = 8'hA5;
        vp = 1'b1;
        @(posedge clk);
        #1;
        vp = 1'b0;
        for (int k = 0; k < 44; k++) begin
            n_cmp++;
            if (txe !== exp_e[k/4]) begin
                n_err++;
                $display("[TB] FAIL 8e1_tx cycle %0d: got %b expected %b", k, txe, exp_e[k/4]);
            end
            n_cmp++;
            if (txo !== exp_o[k/4]) begin
                n_err++;
                $display("[TB] FAIL 8o1_tx cycle %0d: got %b expected %b", k, txo, exp_o[k/4]);
            end
            n_cmp++;
            if (be !== 1'b1 || bo !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL parity_busy cycle %0d: got even/odd busy=%b%b expected 11", k, be, bo);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({fe, fo, be, bo} !== 4'b1100) begin
            n_err++;
            $display("[TB] FAIL parity_done: got done_e/done_o/busy_e/busy_o=%b expected 1100", {fe, fo, be, bo});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_7n2();
        logic [15:0] exp_bits;
        exp_bits = {6'b0, 2'b11, 7'h7F, 1'b0};
        d7 = 7'h7F;
        v7 = 1'b1;
        @(posedge clk);
        #1;
        v7 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            n_cmp++;
            if (tx7 !== exp_bits[k/4]) begin
                n_err++;
                $display("[TB] FAIL 7n2_tx cycle %0d: got %b expected %b", k, tx7, exp_bits[k/4]);
            end
            n_cmp++;
            if (b7 !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL 7n2_busy cycle %0d: got %b expected 1", k, b7);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({f7, r7, b7, tx7} !== 4'b1101) begin
            n_err++;
            $display("[TB] FAIL 7n2_done: got done/ready/busy/tx=%b expected 1101", {f7, r7, b7, tx7});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        int cnt0;
        exp_a = {6'b0, 1'b1, 8'h55, 1'b0};
        exp_b = {6'b0, 1'b1, 8'hAA, 1'b0};
        cnt0 = done_cnt1;
        d1 = 8'h55;
        v1 = 1'b1;
        @(posedge clk);
        #1;
        d1 = 8'hAA;
        for (int k = 0; k < 40; k++) begin
            n_cmp++;
            if (tx1 !== exp_a[k/4]) begin
                n_err++;
                $display("[TB] FAIL b2b_first_tx cycle %0d: got %b expected %b", k, tx1, exp_a[k/4]);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({f1, r1, tx1} !== 3'b111) begin
            n_err++;
            $display("[TB] FAIL b2b_handoff: got done/ready/tx=%b expected 111", {f1, r1, tx1});
        end
        @(posedge clk);
        #1;
        v1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            n_cmp++;
            if (tx1 !== exp_b[k/4]) begin
                n_err++;
                $display("[TB] FAIL b2b_second_tx cycle %0d: got %b expected %b", k, tx1, exp_b[k/4]);
            end
            n_cmp++;
            if (b1 !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL b2b_second_busy cycle %0d: got %b expected 1", k, b1);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (f1 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL b2b_second_done: got %b expected 1", f1);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt1 - cnt0 !== 2) begin
            n_err++;
            $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_cnt1 - cnt0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] exp_bits;
        int seen;
        exp_bits = {6'b0, 1'b1, 8'hA5, 1'b0};
        seen = 0;
        d1 = 8'h5A;
        v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        for (int k = 0; k < 13; k++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({tx1, b1} !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL rst_mid_before: got tx/busy=%b expected 01", {tx1, b1});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx1, r1, b1, f1} !== 4'b1100) begin
            n_err++;
            $display("[TB] FAIL rst_mid_abort: got tx/ready/busy/done=%b expected 1100", {tx1, r1, b1, f1});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d1 = 8'hA5;
        v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            n_cmp++;
            if (tx1 !== exp_bits[k/4]) begin
                n_err++;
                $display("[TB] FAIL rst_mid_next_tx cycle %0d: got %b expected %b", k, tx1, exp_bits[k/4]);
            end
            if (f1 === 1'b1) seen++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("[TB] FAIL rst_mid_residual_done: got %0d pulses expected 0", seen);
        end
        n_cmp++;
        if (f1 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rst_mid_next_done: got %b expected 1", f1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_data_change();
        logic [15:0] exp_bits;
        exp_bits = {6'b0, 1'b1, 8'h3C, 1'b0};
        d1 = 8'h3C;
        v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) begin
                d1 = 8'hFF;
                v1 = 1'b1;
            end
            if (k == 20) v1 = 1'b0;
            n_cmp++;
            if (tx1 !== exp_bits[k/4]) begin
                n_err++;
                $display("[TB] FAIL data_change_tx cycle %0d: got %b expected %b", k, tx1, exp_bits[k/4]);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (f1 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL data_change_done: got %b expected 1", f1);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({b1, tx1, r1} !== 3'b011) begin
            n_err++;
            $display("[TB] FAIL data_change_idle: got busy/tx/ready=%b expected 011", {b1, tx1, r1});
        end
    endtask

    // Runs every scenario in order, then reports
    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_7n2();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Stops a run that somehow stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter FREQ, default 12500000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1, single clock; all logic is rising-edge on clk.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port tx_data, input, DATA_BITS, byte to send.
REQ-009 SHALL have port tx_valid, input, 1, tx_data is valid.
REQ-010 SHALL have port tx_ready, output, 1, block accepts a frame this cycle.
REQ-011 SHALL have port tx, output, 1, serial line; idle high.
REQ-012 SHALL have port busy, output, 1, frame in progress.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse after each frame completes.

Function
REQ-014 SHALL compute DIV = FREQ/BAUD with integer truncation, elaborated as a constant; elaboration SHALL fail if DIV < 2 or if any parameter is outside its legal range.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PAR, STOP.
REQ-016 SHALL drive tx_ready=1 only in IDLE; handshake = tx_valid & tx_ready at a rising edge.
REQ-017 On handshake, SHALL register tx_data into a shift register and enter START; tx SHALL go low on the cycle after the handshake edge.
REQ-018 SHALL hold every bit on tx for exactly DIV clk cycles using a baud counter that counts 0..DIV-1 and wraps.
REQ-019 SHALL transmit data LSB first in DATA, with a bit counter running 0..DATA_BITS-1.
REQ-020 SHALL enter PAR after DATA when PARITY != 0, otherwise go directly to STOP.
REQ-021 SHALL send a parity bit in PAR: even mode makes the count of ones in data plus parity even; odd mode makes it odd.
REQ-022 SHALL drive tx=1 for STOP_BITS x DIV cycles in STOP, then return to IDLE.
REQ-023 Total frame length SHALL be DIV x (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
REQ-024 SHALL assert frame_done for exactly the first IDLE cycle after STOP, with tx_ready=1 in that same cycle.
REQ-025 If a handshake occurs in that same cycle, SHALL start the next frame with zero idle gap, i.e. the stop bit is followed immediately by the next start bit.
REQ-026 SHALL assert busy whenever the state is not IDLE.
REQ-027 SHALL ignore changes on tx_data or tx_valid while busy; the captured frame SHALL be sent unaltered.
REQ-028 SHALL register tx directly from a flop so that it is glitch-free.

Reset
REQ-029 On rst_n=0, SHALL asynchronously force: state IDLE, tx=1, tx_ready=1, busy=0, frame_done=0, and all counters and the shift register to 0.
REQ-030 If reset is asserted mid-frame, SHALL abort the frame immediately with tx=1; after reset release there SHALL be no residual frame_done.
REQ-031 SHALL accept a handshake on the first rising edge after rst_n deasserts.

Verification (FREQ=12500000, BAUD=3125000, so DIV=4)
REQ-032 8N1, send 0xA5 -> tx sequence of 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; 40-cycle frame; frame_done pulses once; busy high for 40 cycles.
REQ-033 8E1, 0xA5 -> parity bit 0; 8O1, 0xA5 -> parity bit 1; 44-cycle frame in each case.
REQ-034 7N2 (DATA_BITS=7, STOP_BITS=2), send 0x7F -> start bit, seven 1 bits, then 8 cycles high; 40-cycle frame; bit 7 of tx_data ignored.
REQ-035 tx_valid held high with data 0x55 then 0xAA -> two back-to-back 40-cycle frames with no idle cycle between the stop bit and the second start bit; frame_done pulses twice.
REQ-036 rst_n pulsed low during the 3rd data bit -> tx=1 in the same cycle, tx_ready=1 and busy=0; the next handshake then produces a clean full frame.
REQ-037 tx_data changed from 0x3C to 0xFF mid-frame -> the transmitted bits still match 0x3C.
